// File: rtl/exe_stage.sv
// EXE pipeline stage: ALU, single-cycle multiplier, divider and store-lane formatting.
// Define EXE_SERIAL_DIV_EN for a 32-step restoring divider FSM; otherwise divides are combinational.
module exe_stage (
   input  logic         clk,
   input  logic         resetn,
   output logic         exe_allowin,
   input  logic         id_to_exe_valid,
   input  logic [157:0] id_to_exe_zip,
   input  logic         mem_allowin,
   output logic         exe_to_mem_valid,
   output logic [74:0]  exe_to_mem_zip,
   output logic [38:0]  exe_rf_zip,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_we,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata
);
   logic         exe_valid_q, exe_valid_d;
   logic [157:0] zip_q, zip_d;
   logic         exe_ready_go;

   logic [18:0]  alu_op;
   logic         res_from_mem, rf_we;
   logic [31:0]  src1, src2, rkd, pc;
   logic [3:0]   mem_op;
   logic [4:0]   rf_waddr;
   assign {alu_op, res_from_mem, src1, src2, mem_op, rf_we, rf_waddr, rkd, pc} = zip_q;

   assign exe_allowin      = ~exe_valid_q | (exe_ready_go & mem_allowin);
   assign exe_to_mem_valid = exe_valid_q & exe_ready_go;

   always_comb begin
      exe_valid_d = exe_valid_q;
      zip_d       = zip_q;
      if (exe_allowin) begin
         exe_valid_d = id_to_exe_valid;
         if (id_to_exe_valid) zip_d = id_to_exe_zip;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exe_valid_q <= 1'b0;
         zip_q       <= '0;
      end else begin
         exe_valid_q <= exe_valid_d;
         zip_q       <= zip_d;
      end
   end

   // Divider front end: magnitudes of the operands, signs remembered for fix-up.
   logic        is_div, div_signed, a_neg, b_neg;
   logic [31:0] a_abs, b_abs, uq, ur, quo, rem;
   assign is_div     = |alu_op[18:15];
   assign div_signed = alu_op[15] | alu_op[16];
   assign a_neg      = div_signed & src1[31];
   assign b_neg      = div_signed & src2[31];
   assign a_abs      = a_neg ? -src1 : src1;
   assign b_abs      = b_neg ? -src2 : src2;

`ifdef EXE_SERIAL_DIV_EN
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
   div_state_e  div_state_q, div_state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [32:0] rem_sh;
   logic [33:0] trial;

   assign rem_sh = {rem_q, quo_q[31]};
   assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

   always_comb begin
      div_state_d = div_state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      case (div_state_q)
         DIV_IDLE: if (exe_valid_q && is_div) begin
            div_state_d = DIV_BUSY;
            cnt_d       = 5'd0;
            rem_d       = 32'd0;
            quo_d       = a_abs;
            dvs_d       = b_abs;
         end
         DIV_BUSY: begin
            if (!trial[33]) begin
               rem_d = trial[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = rem_sh[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) div_state_d = DIV_DONE;
         end
         DIV_DONE: if (mem_allowin) div_state_d = DIV_IDLE;
         default:  div_state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_state_q <= DIV_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
      end else begin
         div_state_q <= div_state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
      end
   end

   assign exe_ready_go = ~is_div | (div_state_q == DIV_DONE);
   assign uq = quo_q;
   assign ur = rem_q;
`else
   assign exe_ready_go = 1'b1;
   assign uq = (b_abs == 32'd0) ? 32'hFFFF_FFFF : a_abs / b_abs;
   assign ur = (b_abs == 32'd0) ? a_abs : a_abs % b_abs;
`endif

   // Zero divisor bypasses sign fix-up; INT_MIN / -1 falls out naturally.
   assign quo = (src2 == 32'd0) ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -uq : uq);
   assign rem = (src2 == 32'd0) ? src1 : (a_neg ? -ur : ur);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] result;
   assign prod_s = $signed(src1) * $signed(src2);
   assign prod_u = src1 * src2;

   always_comb begin
      result = 32'd0;
      if (alu_op[0])  result = result | (src1 + src2);
      if (alu_op[1])  result = result | (src1 - src2);
      if (alu_op[2])  result = result | {31'd0, $signed(src1) < $signed(src2)};
      if (alu_op[3])  result = result | {31'd0, src1 < src2};
      if (alu_op[4])  result = result | (src1 & src2);
      if (alu_op[5])  result = result | ~(src1 | src2);
      if (alu_op[6])  result = result | (src1 | src2);
      if (alu_op[7])  result = result | (src1 ^ src2);
      if (alu_op[8])  result = result | (src1 << src2[4:0]);
      if (alu_op[9])  result = result | (src1 >> src2[4:0]);
      if (alu_op[10]) result = result | 32'($signed(src1) >>> src2[4:0]);
      if (alu_op[11]) result = result | src2;
      if (alu_op[12]) result = result | prod_u[31:0];
      if (alu_op[13]) result = result | prod_s[63:32];
      if (alu_op[14]) result = result | prod_u[63:32];
      if (alu_op[15] | alu_op[17]) result = result | quo;
      if (alu_op[16] | alu_op[18]) result = result | rem;
   end

   assign exe_to_mem_zip = {res_from_mem, mem_op, rf_we, rf_waddr, result, pc};
   assign exe_rf_zip     = {exe_valid_q & (res_from_mem | (is_div & ~exe_ready_go)),
                            exe_valid_q & rf_we, rf_waddr, result};

   assign data_sram_en   = exe_valid_q & exe_ready_go & mem_allowin & (res_from_mem | mem_op[2]);
   assign data_sram_addr = result;

   always_comb begin
      data_sram_we    = 4'b0000;
      data_sram_wdata = rkd;
      case (mem_op)
         4'd4: begin
            data_sram_we    = 4'b0001 << result[1:0];
            data_sram_wdata = {4{rkd[7:0]}};
         end
         4'd5: begin
            data_sram_we    = result[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{rkd[15:0]}};
         end
         4'd6: data_sram_we = 4'b1111;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: scoreboard of expected EXE results, checked as they reach MEM.
module tb_exe_stage;
`ifdef EXE_SERIAL_DIV_EN
   localparam bit SERIAL = 1'b1;
`else
   localparam bit SERIAL = 1'b0;
`endif
   logic         clk = 1'b0, resetn = 1'b0;
   logic         exe_allowin, id_to_exe_valid = 1'b0, mem_allowin = 1'b1;
   logic [157:0] id_to_exe_zip = '0;
   logic         exe_to_mem_valid;
   logic [74:0]  exe_to_mem_zip;
   logic [38:0]  exe_rf_zip;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr, data_sram_wdata;

   exe_stage dut (
      .clk(clk), .resetn(resetn), .exe_allowin(exe_allowin),
      .id_to_exe_valid(id_to_exe_valid), .id_to_exe_zip(id_to_exe_zip),
      .mem_allowin(mem_allowin), .exe_to_mem_valid(exe_to_mem_valid),
      .exe_to_mem_zip(exe_to_mem_zip), .exe_rf_zip(exe_rf_zip),
      .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] pc;
      int          lat;
      logic        en;
      logic [3:0]  we;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0, errors = 0;
   logic [31:0] pc_r = 32'h1c00_0000;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [157:0] mk_zip(input int op, input logic [31:0] s1, input logic [31:0] s2,
                                           input logic [3:0] mop, input logic rfwe, input logic [4:0] wa,
                                           input logic [31:0] rkd, input logic [31:0] pc);
      logic [18:0] a;
      a = '0;
      a[op] = 1'b1;
      return {a, 1'b0, s1, s2, mop, rfwe, wa, rkd, pc};
   endfunction

   // Issue one instruction, then follow it until MEM takes it.
   task automatic issue(input string tag, input int op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [3:0] mop, input logic [31:0] rkd, input logic rfwe, input int hold,
                        input logic [31:0] eres, input logic [3:0] ewe, input logic [31:0] ewd);
      exp_t e, got;
      int   lat;
      bit   seen;
      bit   dv;
      @(negedge clk);
      chk({tag, "_allowin_idle"}, exe_allowin, 1);
      dv          = (op >= 15);
      mem_allowin = (hold == 0);
      pc_r        = pc_r + 32'd4;
      e.res = eres; e.rf_we = rfwe; e.waddr = pc_r[6:2]; e.pc = pc_r;
      e.lat = (SERIAL && dv) ? 34 : 1;
      e.en = mop[2]; e.we = ewe; e.wdata = ewd;
      sb.push_back(e);
      id_to_exe_valid = 1'b1;
      id_to_exe_zip   = mk_zip(op, s1, s2, mop, rfwe, pc_r[6:2], rkd, pc_r);
      @(negedge clk);
      id_to_exe_valid = 1'b0;
      id_to_exe_zip   = '0;
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         if (exe_to_mem_valid) begin
            seen = 1'b1;
            lat  = c;
         end else begin
            if (SERIAL && dv) begin
               chk({tag, "_stall_fwd"}, exe_rf_zip[38], 1);
               chk({tag, "_stall_allowin"}, exe_allowin, 0);
            end
            @(negedge clk);
         end
      end
      chk({tag, "_out_valid"}, seen, 1);
      if (seen && sb.size() > 0) begin
         got = sb.pop_front();
         chk({tag, "_latency"}, lat, got.lat);
         for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_valid"}, exe_to_mem_valid, 1);
            chk({tag, "_hold_result"}, exe_to_mem_zip[63:32], got.res);
            chk({tag, "_hold_allowin"}, exe_allowin, 0);
            chk({tag, "_hold_en"}, data_sram_en, 0);
            @(negedge clk);
         end
         mem_allowin = 1'b1;
         #1;
         chk({tag, "_result"}, exe_to_mem_zip[63:32], got.res);
         chk({tag, "_fwd_result"}, exe_rf_zip[31:0], got.res);
         chk({tag, "_rf_we"}, exe_rf_zip[37], got.rf_we);
         chk({tag, "_waddr"}, exe_to_mem_zip[68:64], got.waddr);
         chk({tag, "_pc"}, exe_to_mem_zip[31:0], got.pc);
         chk({tag, "_fwd_mem"}, exe_rf_zip[38], 0);
         chk({tag, "_allowin_done"}, exe_allowin, 1);
         chk({tag, "_sram_en"}, data_sram_en, got.en);
         chk({tag, "_sram_we"}, data_sram_we, got.we);
         if (got.en) begin
            chk({tag, "_sram_addr"}, data_sram_addr, got.res);
            chk({tag, "_sram_wdata"}, data_sram_wdata, got.wdata);
         end
      end
   endtask

   initial begin
      int nvalid;
      #1;
      chk("rst_allowin", exe_allowin, 1);
      chk("rst_valid", exe_to_mem_valid, 0);
      chk("rst_mem_zip", exe_to_mem_zip, 0);
      chk("rst_rf_zip", exe_rf_zip, 0);
      chk("rst_sram_en", data_sram_en, 0);
      chk("rst_sram_we", data_sram_we, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      issue("add",    0, 32'd5, 32'd7, 4'd0, 0, 1, 0, 32'd12, 4'd0, 0);
      issue("sub",    1, 32'd5, 32'd7, 4'd0, 0, 1, 0, 32'hFFFF_FFFE, 4'd0, 0);
      issue("slt",    2, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, 1, 0, 32'd1, 4'd0, 0);
      issue("sltu",   3, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, 1, 0, 32'd0, 4'd0, 0);
      issue("and",    4, 32'h0000_F0F0, 32'h0000_FF00, 4'd0, 0, 1, 0, 32'h0000_F000, 4'd0, 0);
      issue("nor",    5, 32'd0, 32'd0, 4'd0, 0, 1, 0, 32'hFFFF_FFFF, 4'd0, 0);
      issue("xor",    7, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 4'd0, 0, 1, 0, 32'h5A5A_5A5A, 4'd0, 0);
      issue("sll",    8, 32'd1, 32'd33, 4'd0, 0, 1, 0, 32'd2, 4'd0, 0);
      issue("srl",    9, 32'h8000_0000, 32'd4, 4'd0, 0, 1, 0, 32'h0800_0000, 4'd0, 0);
      issue("sra",   10, 32'h8000_0000, 32'd4, 4'd0, 0, 1, 0, 32'hF800_0000, 4'd0, 0);
      issue("lui",   11, 32'd0, 32'h1234_5000, 4'd0, 0, 1, 0, 32'h1234_5000, 4'd0, 0);
      issue("st_h",   0, 32'h0000_1000, 32'd2, 4'd5, 32'h1234_ABCD, 0, 0, 32'h0000_1002, 4'b1100, 32'hABCD_ABCD);
      issue("st_b",   0, 32'h0000_1000, 32'd1, 4'd4, 32'h0000_0077, 0, 0, 32'h0000_1001, 4'b0010, 32'h7777_7777);
      issue("st_w",   0, 32'h0000_2000, 32'd0, 4'd6, 32'hDEAD_BEEF, 0, 0, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF);
      issue("mul_w", 12, 32'hFFFF_FFFF, 32'd3, 4'd0, 0, 1, 0, 32'hFFFF_FFFD, 4'd0, 0);
      issue("mulh_wu",14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 0, 1, 3, 32'hFFFF_FFFE, 4'd0, 0);
      issue("mulh_w",13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 0, 1, 0, 32'h0000_0000, 4'd0, 0);
      issue("div_w", 15, 32'hFFFF_FFF9, 32'd2, 4'd0, 0, 1, 0, 32'hFFFF_FFFD, 4'd0, 0);
      issue("mod_w", 16, 32'hFFFF_FFF9, 32'd2, 4'd0, 0, 1, 0, 32'hFFFF_FFFF, 4'd0, 0);
      issue("divwu0",17, 32'd9, 32'd0, 4'd0, 0, 1, 0, 32'hFFFF_FFFF, 4'd0, 0);
      issue("modwu0",18, 32'd9, 32'd0, 4'd0, 0, 1, 0, 32'd9, 4'd0, 0);
      issue("div_ovf",15, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 0, 1, 0, 32'h8000_0000, 4'd0, 0);
      issue("mod_ovf",16, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 0, 1, 0, 32'd0, 4'd0, 0);
      issue("divwu", 17, 32'd100, 32'd7, 4'd0, 0, 1, 2, 32'd14, 4'd0, 0);
      issue("modwu", 18, 32'd100, 32'd7, 4'd0, 0, 1, 0, 32'd2, 4'd0, 0);

      // Reset lands mid-divide (counter at 10 in the serial build).
      @(negedge clk);
      mem_allowin     = 1'b0;
      id_to_exe_valid = 1'b1;
      id_to_exe_zip   = mk_zip(15, 32'd100, 32'd3, 4'd0, 1'b1, 5'd3, 32'd0, 32'h40);
      @(negedge clk);
      id_to_exe_valid = 1'b0;
      id_to_exe_zip   = '0;
      repeat (11) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midrst_allowin", exe_allowin, 1);
      chk("midrst_valid", exe_to_mem_valid, 0);
      chk("midrst_rf_zip", exe_rf_zip, 0);
      chk("midrst_mem_zip", exe_to_mem_zip, 0);
      chk("midrst_sram_en", data_sram_en, 0);
      @(negedge clk);
      resetn      = 1'b1;
      mem_allowin = 1'b1;
      nvalid      = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (exe_to_mem_valid) nvalid++;
      end
      chk("midrst_no_stale", nvalid, 0);
      issue("add_post", 0, 32'd40, 32'd2, 4'd0, 0, 1, 0, 32'd42, 4'd0, 0);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: exe_allowin  out  1  stage can accept from ID.
REQ-004 SHALL have port: id_to_exe_valid  in  1  ID offers an instruction.
REQ-005 SHALL have port: id_to_exe_zip  in  158  {alu_op[18:0], res_from_mem, alu_src1[31:0], alu_src2[31:0], mem_op[3:0], rf_we, rf_waddr[4:0], rkd_value[31:0], pc[31:0]}.
REQ-006 SHALL have port: mem_allowin  in  1  MEM stage can accept.
REQ-007 SHALL have port: exe_to_mem_valid  out  1  result offered to MEM.
REQ-008 SHALL have port: exe_to_mem_zip  out  75  {res_from_mem, mem_op[3:0], rf_we, rf_waddr[4:0], result[31:0], pc[31:0]}.
REQ-009 SHALL have port: exe_rf_zip  out  39  {exe_res_from_mem, exe_rf_we, exe_rf_waddr[4:0], result[31:0]} forwarding/stall to ID.
REQ-010 SHALL have ports: data_sram_en out 1; data_sram_we out 4; data_sram_addr out 32; data_sram_wdata out 32.

Function
REQ-011 SHALL compute exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin); exe_to_mem_valid = exe_valid & exe_ready_go.
REQ-012 SHALL capture id_to_exe_zip and set exe_valid when id_to_exe_valid & exe_allowin; clear exe_valid when exe_allowin & ~id_to_exe_valid; hold otherwise.
REQ-013 SHALL evaluate alu_op[11:0] (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui) combinationally on captured operands, shifts using src2[4:0]; exe_ready_go=1 for these.
REQ-014 SHALL compute mul.w/mulh.w/mulh.wu (alu_op[12:14]) as a single-cycle 64-bit product, low or high word, signed/unsigned per op.
REQ-015 SHALL compute div.w/mod.w/div.wu/mod.wu (alu_op[15:18]); divide by zero gives quotient 32'hFFFFFFFF, remainder = src1; 32'h80000000 / -1 gives quotient 32'h80000000, remainder 0.
REQ-016 SHALL drive exe_rf_we = exe_valid & rf_we; exe_res_from_mem = exe_valid & (res_from_mem | (divide op & ~exe_ready_go)), so ID stalls on an unfinished divide.
REQ-017 SHALL assert data_sram_en = exe_valid & exe_ready_go & mem_allowin & (res_from_mem | mem_op[2]); addr = result.
REQ-018 SHALL drive stores only when mem_op[2]: mem_op 4 (st.b) we = 4'b0001 << addr[1:0], wdata = {4{rkd[7:0]}}; 5 (st.h) we = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rkd[15:0]}}; 6 (st.w) we = 4'b1111, wdata = rkd; else we = 0.
REQ-019 SHALL pass res_from_mem, mem_op, rf_we, rf_waddr, pc unchanged into exe_to_mem_zip.

Reset
REQ-020 SHALL on resetn low, asynchronously clear exe_valid, all zip registers, divider state (IDLE), counter and partial results; all outputs 0 except exe_allowin = 1.
REQ-021 SHALL abandon any division in progress on reset; no result is emitted afterwards.

Configuration
REQ-022 SHALL, with EXE_SERIAL_DIV_EN defined, divide with a radix-2 restoring FSM: IDLE -> BUSY on first cycle a valid divide is resident (load |operands|, count = 0); BUSY for 32 cycles, count 0..31; BUSY -> DONE after count 31; DONE -> IDLE when mem_allowin; exe_ready_go = 1 only in DONE; signs fixed up from captured operand signs.
REQ-023 SHALL, with EXE_SERIAL_DIV_EN defined, complete a divide 33 cycles after capture (exe_to_mem_valid first high on the 34th resident cycle), holding result stable while mem_allowin is low.
REQ-024 SHALL, without EXE_SERIAL_DIV_EN, compute divides combinationally in one cycle with identical REQ-015 results; FSM absent.

Verification
REQ-025 SHALL cover: add.w src1=5, src2=7, mem_allowin=1 -> next cycle exe_to_mem_valid=1, result=12, exe_rf_we=1.
REQ-026 SHALL cover: st.h addr=0x1002, rkd=0x1234ABCD -> data_sram_we=4'b1100, wdata=0xABCDABCD, en=1.
REQ-027 SHALL cover (serial): div.w -7/2 -> exe_res_from_mem=1 and exe_allowin=0 for 33 cycles, then result 0xFFFFFFFD; mod.w same operands -> 0xFFFFFFFF.
REQ-028 SHALL cover: div.wu 9/0 -> 0xFFFFFFFF; mod.wu 9/0 -> 9; div.w 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-029 SHALL cover: mulh.wu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulh.w same -> 0x00000000; with mem_allowin=0 for 3 cycles -> outputs held, exe_allowin=0.
REQ-030 SHALL cover: resetn low at BUSY count 10 -> exe_valid=0 immediately; after release a new add.w completes normally in one cycle.
